thread_issue_sched: RTL and testbench
=====================================

THREAD_ISSUE_SCHED -- requirements
Module: thread_issue_sched

Interface
REQ-001: The block SHALL have parameter NTHREAD, default 8, giving the number of hardware threads (power of two, 2..64).
REQ-002: The block SHALL have parameter TIDW, default log2(NTHREAD), giving the thread-id width.
REQ-003: The block SHALL have parameter PIPEDEPTH, default 7, giving the minimum number of cycles between two issues of the same thread (no intra-thread bypass).
REQ-004: The block SHALL have port clk, input, 1 bit, the single clock; all state is rising-edge clocked.
REQ-005: The block SHALL have port rstn, input, 1 bit, reset, asynchronous and active-low.
REQ-006: The block SHALL have port run_set, input, 1 bit, setting the run bit of run_set_tid.
REQ-007: The block SHALL have port run_set_tid, input, TIDW bits, the target thread of run_set.
REQ-008: The block SHALL have port run_clr, input, 1 bit, clearing the run bit of run_clr_tid (error mode/halt).
REQ-009: The block SHALL have port run_clr_tid, input, TIDW bits, the target thread of run_clr.
REQ-010: The block SHALL have port stall, input, 1 bit, marking stall_tid stalled (icache miss or replay).
REQ-011: The block SHALL have port stall_tid, input, TIDW bits, the target thread of stall.
REQ-012: The block SHALL have port wake, input, 1 bit, un-stalling wake_tid (refill done).
REQ-013: The block SHALL have port wake_tid, input, TIDW bits, the target thread of wake.
REQ-014: The block SHALL have port issue_en, input, 1 bit, meaning the pipeline accepts an issue this cycle.
REQ-015: The block SHALL have port issue_valid, output, 1 bit, meaning issue_tid is valid this cycle.
REQ-016: The block SHALL have port issue_tid, output, TIDW bits, the issued thread id.
REQ-017: The block SHALL have port issue_parity, output, 1 bit, the even parity (XOR) of issue_tid.
REQ-018: The block SHALL have port run_mask, output, NTHREAD bits, the current run bit of every thread.
REQ-019: The block SHALL have port stall_mask, output, NTHREAD bits, the current stall bit of every thread.

Function
REQ-020: Each thread SHALL hold a run bit, a stall bit and a cooldown counter of width log2(PIPEDEPTH)+1.
REQ-021: A thread SHALL be eligible when run=1, stall=0 and cooldown=0.
REQ-022: The arbiter SHALL perform round-robin selection: search from (last_tid+1) mod NTHREAD upward with wrap and pick the first eligible thread.
REQ-023: In a cycle where issue_en=1 and at least one thread is eligible, the block SHALL register issue_valid=1, issue_tid=<winner> and issue_parity=^winner, visible on the next cycle (1-cycle latency).
REQ-024: In a cycle where issue_en=1 and a thread is issued, last_tid SHALL update to the winner and that thread's cooldown SHALL load PIPEDEPTH-1.
REQ-025: In a cycle where issue_en=0 or no thread is eligible, the block SHALL register issue_valid=0, hold issue_tid, and leave last_tid unchanged.
REQ-026: Every nonzero cooldown counter SHALL decrement by 1 each cycle regardless of issue_en, saturating at 0.
REQ-027: With PIPEDEPTH=1 a thread SHALL be eligible to issue on consecutive cycles.
REQ-028: Set/clear precedence: run_clr SHALL win over run_set for the same tid in the same cycle.
REQ-029: Set/clear precedence: stall SHALL win over wake for the same tid in the same cycle.
REQ-030: Events that target different tids SHALL all take effect in the same cycle.
REQ-031: Updates to run, stall and cooldown SHALL take effect at the clock edge, so the arbiter sees the new state one cycle after the event.
REQ-032: A thread stalled in cycle N SHALL not be issued in cycle N, even if it was eligible at the start of cycle N.
REQ-033: run_clr of a thread SHALL also clear its stall bit and cooldown; a thread with run=0 SHALL never issue.
REQ-034: A wake aimed at a non-stalled thread, and a stall aimed at a thread with run=0, SHALL be ignored.
REQ-035: run_mask and stall_mask SHALL be direct register outputs with no combinational path from the inputs.

Reset
REQ-036: While rstn=0 the block SHALL drive issue_valid=0, issue_tid=0, issue_parity=0, run_mask=0 and stall_mask=0, set all cooldowns to 0, and set last_tid=NTHREAD-1, so that thread 0 is searched first.
REQ-037: Assertion of rstn mid-operation SHALL take effect immediately (asynchronously) and discard all pending stalls and cooldowns.
REQ-038: Release of rstn SHALL be synchronous; the first issue SHALL be possible on the second rising edge after a run_set.

Verification
REQ-039: Bench scenario, reset then run_set for tids 0..7, PIPEDEPTH=7, issue_en=1 -> issue_tid sequence 0,1,...,7,0,1,... with issue_valid=1 every cycle.
REQ-040: Bench scenario, only tid 3 running, PIPEDEPTH=7 -> issue_valid=1 for tid 3 once every 7 cycles and 0 otherwise, with issue_parity=0.
REQ-041: Bench scenario, tids 2 and 5 running, stall tid 2 for 10 cycles then wake -> only tid 5 issues (every 7 cycles) while tid 2 is stalled, and tid 2 issues again within PIPEDEPTH cycles after wake with correct round-robin order.
REQ-042: Bench scenario, same-cycle run_set and run_clr on tid 4 -> run_mask[4]=0; same-cycle stall and wake on tid 1 -> stall_mask[1]=1.
REQ-043: Bench scenario, issue_en toggled 0/1 with all threads running -> no tid is skipped or repeated, and last_tid holds while issue_en=0.
REQ-044: Bench scenario, rstn asserted for 1 cycle mid-stream -> all outputs return to 0 immediately, and after a fresh run_set of tid 6 the first issue is tid 6.

Source files
------------

// File: rtl/thread_issue_sched.sv
// Barrel-style thread issue scheduler: per-thread run/stall/cooldown state and a
// round-robin arbiter that registers one issued thread id per cycle.
module thread_issue_sched #(
  parameter int NTHREAD   = 8,
  parameter int TIDW      = $clog2(NTHREAD),
  parameter int PIPEDEPTH = 7
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               run_set,
  input  logic [TIDW-1:0]    run_set_tid,
  input  logic               run_clr,
  input  logic [TIDW-1:0]    run_clr_tid,
  input  logic               stall,
  input  logic [TIDW-1:0]    stall_tid,
  input  logic               wake,
  input  logic [TIDW-1:0]    wake_tid,
  input  logic               issue_en,
  output logic               issue_valid,
  output logic [TIDW-1:0]    issue_tid,
  output logic               issue_parity,
  output logic [NTHREAD-1:0] run_mask,
  output logic [NTHREAD-1:0] stall_mask
);

  localparam int              CDW      = $clog2(PIPEDEPTH) + 1;
  localparam logic [CDW-1:0]  CD_LOAD  = CDW'(PIPEDEPTH - 1);
  localparam logic [TIDW-1:0] LAST_RST = TIDW'(NTHREAD - 1);

  logic [NTHREAD-1:0] run_q, run_d;
  logic [NTHREAD-1:0] stall_q, stall_d;
  logic [NTHREAD-1:0] elig;
  logic [TIDW-1:0]    last_q, last_d;
  logic               valid_q, valid_d;
  logic [TIDW-1:0]    tid_q, tid_d;
  logic               par_q, par_d;

  logic               found;
  logic               fire;
  logic [TIDW-1:0]    win;
  logic [TIDW-1:0]    scan_idx;

  for (genvar gi = 0; gi < NTHREAD; gi++) begin : g_thr
    localparam logic [TIDW-1:0] TID = TIDW'(gi);

    logic           set_hit, clr_hit, stall_hit, wake_hit;
    logic [CDW-1:0] cd_q, cd_d;

    assign set_hit   = run_set && (run_set_tid == TID);
    assign clr_hit   = run_clr && (run_clr_tid == TID);
    assign stall_hit = stall   && (stall_tid   == TID);
    assign wake_hit  = wake    && (wake_tid    == TID);

    // Halt beats start; stall beats wake; stall on a halted thread is dropped.
    assign run_d[gi]   = !clr_hit && (set_hit || run_q[gi]);
    assign stall_d[gi] = !clr_hit &&
                         ((stall_hit && run_q[gi]) || (stall_q[gi] && !wake_hit));

    // A same-cycle stall or halt blocks the thread even if it was otherwise ready.
    assign elig[gi] = run_q[gi] && !stall_q[gi] && (cd_q == '0) && !stall_hit && !clr_hit;

    always_comb begin
      cd_d = cd_q;
      if (clr_hit) begin
        cd_d = '0;
      end else if (fire && (win == TID)) begin
        cd_d = CD_LOAD;
      end else if (cd_q != '0) begin
        cd_d = cd_q - CDW'(1);
      end
    end

    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        cd_q <= '0;
      end else begin
        cd_q <= cd_d;
      end
    end
  end

  // Scan upward from last_q+1; the final step wraps back onto last_q itself.
  always_comb begin
    found    = 1'b0;
    win      = last_q;
    scan_idx = '0;
    for (int k = 1; k <= NTHREAD; k++) begin
      scan_idx = last_q + TIDW'(k);
      if (!found && elig[scan_idx]) begin
        found = 1'b1;
        win   = scan_idx;
      end
    end
  end

  assign fire = issue_en && found;

  always_comb begin
    valid_d = 1'b0;
    tid_d   = tid_q;
    par_d   = par_q;
    last_d  = last_q;
    if (fire) begin
      valid_d = 1'b1;
      tid_d   = win;
      par_d   = ^win;
      last_d  = win;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      run_q   <= '0;
      stall_q <= '0;
      last_q  <= LAST_RST;
      valid_q <= 1'b0;
      tid_q   <= '0;
      par_q   <= 1'b0;
    end else begin
      run_q   <= run_d;
      stall_q <= stall_d;
      last_q  <= last_d;
      valid_q <= valid_d;
      tid_q   <= tid_d;
      par_q   <= par_d;
    end
  end

  assign issue_valid  = valid_q;
  assign issue_tid    = tid_q;
  assign issue_parity = par_q;
  assign run_mask     = run_q;
  assign stall_mask   = stall_q;

endmodule

// File: tb/tb_thread_issue_sched.sv
// Scoreboard bench for thread_issue_sched: directed scenarios push expected
// (tid, parity, cycle) records; a negedge monitor pops them as issues appear.
module tb_thread_issue_sched;
  localparam int NT = 8;
  localparam int TW = 3;
  localparam int PD = 7;

  logic          clk = 1'b0;
  logic          rstn = 1'b1;
  logic          run_set = 1'b0;
  logic [TW-1:0] run_set_tid = '0;
  logic          run_clr = 1'b0;
  logic [TW-1:0] run_clr_tid = '0;
  logic          stall = 1'b0;
  logic [TW-1:0] stall_tid = '0;
  logic          wake = 1'b0;
  logic [TW-1:0] wake_tid = '0;
  logic          issue_en = 1'b0;
  logic          issue_valid;
  logic [TW-1:0] issue_tid;
  logic          issue_parity;
  logic [NT-1:0] run_mask;
  logic [NT-1:0] stall_mask;

  thread_issue_sched #(.NTHREAD(NT), .TIDW(TW), .PIPEDEPTH(PD)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .run_set      (run_set),
    .run_set_tid  (run_set_tid),
    .run_clr      (run_clr),
    .run_clr_tid  (run_clr_tid),
    .stall        (stall),
    .stall_tid    (stall_tid),
    .wake         (wake),
    .wake_tid     (wake_tid),
    .issue_en     (issue_en),
    .issue_valid  (issue_valid),
    .issue_tid    (issue_tid),
    .issue_parity (issue_parity),
    .run_mask     (run_mask),
    .stall_mask   (stall_mask)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int tid;
    int par;
    int at;
  } exp_t;

  exp_t       sb[$];
  exp_t       mon_e;
  int         n_pass = 0;
  int         n_total = 0;
  bit         armed = 1'b0;
  logic [7:0] par_tab = 8'b1001_0110;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
  endtask

  task automatic expect_issue(input int tid, input int at);
    exp_t e;
    e.tid = tid;
    e.par = int'(par_tab[tid]);
    e.at  = at;
    sb.push_back(e);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ev;
    run_set = 1'b0;
    run_clr = 1'b0;
    stall   = 1'b0;
    wake    = 1'b0;
  endtask

  // Asserts reset between clock edges, checks outputs drop at once, releases after an edge.
  task automatic do_reset;
    @(negedge clk);
    #1;
    chk("drained", 64'(sb.size()), 64'd0);
    sb.delete();
    rstn = 1'b0;
    clear_ev();
    #1;
    chk("rst_valid", 64'(issue_valid), 64'd0);
    chk("rst_tid", 64'(issue_tid), 64'd0);
    chk("rst_parity", 64'(issue_parity), 64'd0);
    chk("rst_run_mask", 64'(run_mask), 64'd0);
    chk("rst_stall_mask", 64'(stall_mask), 64'd0);
    @(posedge clk);
    #1;
    rstn  = 1'b1;
    armed = 1'b1;
  endtask

  always @(negedge clk) begin
    if (armed && issue_valid) begin
      $display("issue cycle %0d tid %0d parity %0d", cyc, issue_tid, issue_parity);
      n_total++;
      if (sb.size() == 0) begin
        $display("FAIL unexpected_issue: got tid %0d at cycle %0d, required no issue", issue_tid, cyc);
      end else begin
        mon_e = sb.pop_front();
        if (int'(issue_tid) == mon_e.tid && int'(issue_parity) == mon_e.par && cyc == mon_e.at)
          n_pass++;
        else
          $display("FAIL issue: got tid %0d par %0d cycle %0d, required tid %0d par %0d cycle %0d",
                   issue_tid, issue_parity, cyc, mon_e.tid, mon_e.par, mon_e.at);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  initial begin
    int          c0;
    int          n;
    logic [19:0] pat;

    do_reset();

    // All eight threads started one per cycle: strict 0..7 rotation, one issue per cycle.
    issue_en = 1'b1;
    c0 = cyc;
    for (int i = 0; i < 24; i++) expect_issue(i % 8, c0 + 2 + i);
    for (int k = 0; k < 8; k++) begin
      run_set = 1'b1;
      run_set_tid = TW'(k);
      tick();
    end
    run_set = 1'b0;
    while (cyc < c0 + 25) tick();
    do_reset();

    // Single thread 3: issues every PIPEDEPTH cycles.
    c0 = cyc;
    expect_issue(3, c0 + 2);
    expect_issue(3, c0 + 9);
    expect_issue(3, c0 + 16);
    expect_issue(3, c0 + 23);
    run_set = 1'b1;
    run_set_tid = 3'd3;
    tick();
    run_set = 1'b0;
    chk("s2_run_mask", 64'(run_mask), 64'h08);
    while (cyc < c0 + 28) tick();
    do_reset();

    // Threads 2 and 5; thread 2 stalled exactly when its cooldown expires, woken 10 cycles later.
    c0 = cyc;
    expect_issue(2, c0 + 2);
    expect_issue(5, c0 + 3);
    expect_issue(5, c0 + 10);
    expect_issue(5, c0 + 17);
    expect_issue(2, c0 + 20);
    expect_issue(5, c0 + 24);
    expect_issue(2, c0 + 27);
    expect_issue(5, c0 + 31);
    run_set = 1'b1;
    run_set_tid = 3'd2;
    tick();
    run_set_tid = 3'd5;
    tick();
    run_set = 1'b0;
    while (cyc < c0 + 8) tick();
    stall = 1'b1;
    stall_tid = 3'd2;
    tick();
    stall = 1'b0;
    chk("s3_stalled", 64'(stall_mask), 64'h04);
    while (cyc < c0 + 18) tick();
    wake = 1'b1;
    wake_tid = 3'd2;
    tick();
    wake = 1'b0;
    chk("s3_woken", 64'(stall_mask), 64'h00);
    while (cyc < c0 + 32) tick();
    do_reset();

    // Event precedence with issue disabled.
    issue_en = 1'b0;
    run_set = 1'b1;
    run_set_tid = 3'd1;
    tick();
    run_set_tid = 3'd4;
    run_clr = 1'b1;
    run_clr_tid = 3'd4;
    tick();
    chk("s4_clr_wins", 64'(run_mask), 64'h02);
    run_set_tid = 3'd7;
    run_clr = 1'b0;
    stall = 1'b1;
    stall_tid = 3'd1;
    wake = 1'b1;
    wake_tid = 3'd1;
    tick();
    chk("s4_run_multi", 64'(run_mask), 64'h82);
    chk("s4_stall_wins", 64'(stall_mask), 64'h02);
    run_set = 1'b0;
    run_clr = 1'b1;
    run_clr_tid = 3'd7;
    stall_tid = 3'd6;
    wake_tid = 3'd0;
    tick();
    chk("s4_ignored_run", 64'(run_mask), 64'h02);
    chk("s4_ignored_stall", 64'(stall_mask), 64'h02);
    clear_ev();
    run_clr = 1'b1;
    run_clr_tid = 3'd1;
    tick();
    run_clr = 1'b0;
    chk("s4_halt_run", 64'(run_mask), 64'h00);
    chk("s4_halt_stall", 64'(stall_mask), 64'h00);
    do_reset();

    // All threads running, issue_en toggled: rotation continues with no skip or repeat.
    issue_en = 1'b0;
    for (int k = 0; k < 8; k++) begin
      run_set = 1'b1;
      run_set_tid = TW'(k);
      tick();
    end
    run_set = 1'b0;
    pat = 20'b1110_0110_1001_1010_1101;
    n = 0;
    for (int j = 0; j < 20; j++) begin
      issue_en = pat[j];
      if (pat[j]) begin
        expect_issue(n % 8, cyc + 1);
        n++;
      end
      tick();
    end
    // Reset lands mid-stream with issue_en still high.
    do_reset();

    // Fresh start after reset: thread 6 first, then 0 joins.
    c0 = cyc;
    expect_issue(6, c0 + 2);
    expect_issue(0, c0 + 3);
    expect_issue(6, c0 + 9);
    expect_issue(0, c0 + 10);
    run_set = 1'b1;
    run_set_tid = 3'd6;
    tick();
    run_set_tid = 3'd0;
    tick();
    run_set = 1'b0;
    while (cyc < c0 + 10) tick();
    @(negedge clk);
    #1;
    chk("final_drained", 64'(sb.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
